// File: rtl/turfio_mode1_arbiter_if.sv
// Mode1 stream bundle between the local requesters and the command splice.
// s_*: NSRC requester lanes (8b data, 2b type); m_*: one beat toward the splice.
interface turfio_mode1_arbiter_if #(
  parameter int NSRC = 4
);
  logic [8*NSRC-1:0] s_tdata;
  logic [2*NSRC-1:0] s_tuser;
  logic [NSRC-1:0]   s_tvalid;
  logic [NSRC-1:0]   s_tlast;
  logic [NSRC-1:0]   s_tready;
  logic [7:0]        m_tdata;
  logic [1:0]        m_tuser;
  logic              m_tvalid;
  logic              m_tready;

  modport master (
    output s_tdata, s_tuser, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tuser, m_tvalid
  );

  modport slave (
    input  s_tdata, s_tuser, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tuser, m_tvalid
  );
endinterface

// File: rtl/turfio_mode1_arbiter.sv
// Round-robin packet arbiter sharing the TURFIO mode1 stream among NSRC sources.
// Ports: sysclk_i/rstn_i, enable_i, bus (slave), grant_o, abort_o, abort_count_o.
module turfio_mode1_arbiter #(
  parameter int NSRC    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                  sysclk_i,
  input  logic                  rstn_i,
  input  logic                  enable_i,
  turfio_mode1_arbiter_if.slave bus,
  output logic [NSRC-1:0]       grant_o,
  output logic                  abort_o,
  output logic [15:0]           abort_count_o
);
  localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int WW = $clog2(TIMEOUT);

  typedef enum logic {IDLE, PKT} state_t;

  state_t          state_q;
  logic [NSRC-1:0] grant_q;
  logic [IW-1:0]   gidx_q;
  logic [IW-1:0]   last_q;
  logic [WW-1:0]   wd_q;
  logic [7:0]      data_q;
  logic [1:0]      user_q;
  logic            mvalid_q;
  logic            abort_q;
  logic [15:0]     abort_count_q;
  logic [15:0]     abort_count_d;

  logic [IW-1:0]   pick;
  logic [IW-1:0]   j;
  logic            pick_ok;
  logic            g_valid;
  logic            g_last;
  logic [7:0]      g_data;
  logic [1:0]      g_user;
  logic            out_free;
  logic            xfer;
  logic            wd_hit;

  // First requester strictly after last_q, ascending with wrap.
  always_comb begin
    pick    = last_q;
    pick_ok = 1'b0;
    j       = '0;
    for (int k = 1; k <= NSRC; k++) begin
      j = IW'((int'(last_q) + k) % NSRC);
      if (!pick_ok && bus.s_tvalid[j]) begin
        pick_ok = 1'b1;
        pick    = j;
      end
    end
  end

  assign g_valid  = bus.s_tvalid[gidx_q];
  assign g_last   = bus.s_tlast[gidx_q];
  assign g_data   = bus.s_tdata[{gidx_q, 3'b000} +: 8];
  assign g_user   = bus.s_tuser[{gidx_q, 1'b0} +: 2];

  // Output register can take a beat when empty or draining this cycle.
  assign out_free = !mvalid_q || bus.m_tready;
  assign xfer     = (state_q == PKT) && g_valid && out_free;

  // Only a missing tvalid counts; backpressure never trips the watchdog.
  assign wd_hit   = (state_q == PKT) && !g_valid &&
                    (wd_q == WW'(TIMEOUT - 1));

  assign abort_count_d = (abort_count_q == 16'hFFFF) ?
                         abort_count_q : abort_count_q + 16'd1;

  assign bus.s_tready = (state_q == PKT && out_free) ?
                        (NSRC'(1) << gidx_q) : '0;
  assign bus.m_tdata  = data_q;
  assign bus.m_tuser  = user_q;
  assign bus.m_tvalid = mvalid_q;
  assign grant_o       = grant_q;
  assign abort_o       = abort_q;
  assign abort_count_o = abort_count_q;

  always_ff @(posedge sysclk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      gidx_q        <= '0;
      last_q        <= IW'(NSRC - 1);
      wd_q          <= '0;
      data_q        <= '0;
      user_q        <= '0;
      mvalid_q      <= 1'b0;
      abort_q       <= 1'b0;
      abort_count_q <= '0;
    end else begin
      abort_q <= 1'b0;
      if (xfer) begin
        mvalid_q <= 1'b1;
        data_q   <= g_data;
        user_q   <= g_user;
      end else if (bus.m_tready) begin
        mvalid_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (enable_i && pick_ok) begin
            state_q <= PKT;
            grant_q <= NSRC'(1) << pick;
            gidx_q  <= pick;
            last_q  <= pick;
            wd_q    <= '0;
          end
        end
        PKT: begin
          if (xfer) begin
            wd_q <= '0;
            if (g_last) begin
              state_q <= IDLE;
              grant_q <= '0;
            end
          end else if (wd_hit) begin
            // last_q keeps the aborted source, sending it to the back.
            state_q       <= IDLE;
            grant_q       <= '0;
            abort_q       <= 1'b1;
            abort_count_q <= abort_count_d;
          end else if (!g_valid) begin
            wd_q <= wd_q + WW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_turfio_mode1_arbiter.sv
// Self-checking bench for turfio_mode1_arbiter.
// Source queues drive requesters; an expected-beat queue checks the output.
`timescale 1ns/1ps
module tb_turfio_mode1_arbiter;
  localparam int NSRC    = 4;
  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] u;
    logic       l;
  } beat_t;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
  } vec_t;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic        en   = 1'b0;
  logic [3:0]  grant;
  logic        abort;
  logic [15:0] acnt;

  turfio_mode1_arbiter_if #(.NSRC(NSRC)) bus ();

  turfio_mode1_arbiter #(.NSRC(NSRC), .TIMEOUT(TIMEOUT)) dut (
    .sysclk_i      (clk),
    .rstn_i        (rstn),
    .enable_i      (en),
    .bus           (bus),
    .grant_o       (grant),
    .abort_o       (abort),
    .abort_count_o (acnt)
  );

  always #5 clk = ~clk;

  beat_t      srcq[NSRC][$];
  beat_t      expq[$];
  logic [3:0] stall;
  logic [3:0] fire;
  logic       rst_v;
  logic       en_n;
  int         mr_mode;
  int         cyc;
  int         checks;
  int         errors;
  vec_t       vt[11];

  function automatic beat_t mk(logic [7:0] d, logic [1:0] u, logic l);
    beat_t b;
    b.d = d;
    b.u = u;
    b.l = l;
    return b;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive();
    beat_t h;
    rstn = rst_v;
    en   = en_n;
    for (int i = 0; i < NSRC; i++) begin
      h = (srcq[i].size() > 0) ? srcq[i][0] : '0;
      bus.s_tvalid[i]       = (srcq[i].size() > 0) && !stall[i];
      bus.s_tdata[8*i +: 8] = h.d;
      bus.s_tuser[2*i +: 2] = h.u;
      bus.s_tlast[i]        = h.l;
    end
    case (mr_mode)
      1:       bus.m_tready = (cyc % 8 == 0);
      2:       bus.m_tready = 1'b0;
      default: bus.m_tready = 1'b1;
    endcase
  endtask

  // Drive at edge+1, sample at edge+9 (one before the next edge).
  task automatic step();
    beat_t e;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NSRC; i++)
      if (fire[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    fire = '0;
    drive();
    #8;
    fire = bus.s_tvalid & bus.s_tready;
    if (bus.m_tvalid && bus.m_tready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_beat got %0h want none", bus.m_tdata);
      end else begin
        e = expq.pop_front();
        chk("beat_data", 32'(bus.m_tdata), 32'(e.d));
        chk("beat_user", 32'(bus.m_tuser), 32'(e.u));
      end
    end
  endtask

  task automatic do_reset();
    rst_v = 1'b0;
    for (int i = 0; i < NSRC; i++) srcq[i].delete();
    expq.delete();
    stall   = '0;
    fire    = '0;
    mr_mode = 0;
    en_n    = 1'b1;
    step();
    step();
    rst_v = 1'b1;
    step();
  endtask

  task automatic wait_grant(int bound);
    for (int n = 0; n < bound && grant == 0; n++) step();
  endtask

  task automatic wait_abort(int bound);
    for (int n = 0; n < bound && !abort; n++) step();
  endtask

  task automatic wait_drain(string nm, int bound);
    for (int n = 0; n < bound && (expq.size() > 0 || grant != 0); n++)
      step();
    chk(nm, 32'(expq.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout got running want done");
    $fatal(1);
  end

  initial begin
    int t;
    int w;
    checks  = 0;
    errors  = 0;
    cyc     = 0;
    stall   = '0;
    fire    = '0;
    mr_mode = 0;
    rst_v   = 1'b0;
    en_n    = 1'b1;

    vt[0]  = '{4'b1111, 4'b0001};
    vt[1]  = '{4'b1111, 4'b0010};
    vt[2]  = '{4'b1001, 4'b1000};
    vt[3]  = '{4'b0110, 4'b0010};
    vt[4]  = '{4'b0101, 4'b0100};
    vt[5]  = '{4'b0011, 4'b0001};
    vt[6]  = '{4'b1000, 4'b1000};
    vt[7]  = '{4'b1000, 4'b1000};
    vt[8]  = '{4'b0001, 4'b0001};
    vt[9]  = '{4'b1110, 4'b0010};
    vt[10] = '{4'b1101, 4'b0100};

    drive();

    // Reset holds everything quiet even with requests pending.
    for (int i = 0; i < NSRC; i++) srcq[i].push_back(mk(8'hEE, 2'd1, 1'b1));
    repeat (3) step();
    chk("rst_grant",  32'(grant), 0);
    chk("rst_mvalid", 32'(bus.m_tvalid), 0);
    chk("rst_mdata",  32'(bus.m_tdata), 0);
    chk("rst_muser",  32'(bus.m_tuser), 0);
    chk("rst_tready", 32'(bus.s_tready), 0);
    chk("rst_abort",  32'(abort), 0);
    chk("rst_acnt",   32'(acnt), 0);

    // Single source, three beats.
    do_reset();
    srcq[1].push_back(mk(8'hA1, 2'b10, 1'b0));
    srcq[1].push_back(mk(8'hA2, 2'b10, 1'b0));
    srcq[1].push_back(mk(8'hA3, 2'b10, 1'b1));
    expq.push_back(mk(8'hA1, 2'b10, 1'b0));
    expq.push_back(mk(8'hA2, 2'b10, 1'b0));
    expq.push_back(mk(8'hA3, 2'b10, 1'b1));
    wait_grant(6);
    chk("t1_grant",  32'(grant), 32'b0010);
    chk("t1_tready", 32'(bus.s_tready), 32'b0010);
    for (int n = 0; n < 10; n++) begin
      if (fire[1] && srcq[1].size() > 0 && srcq[1][0].l) break;
      step();
    end
    step();
    chk("t1_grant_off", 32'(grant), 0);
    chk("t1_last_out",  32'(bus.m_tvalid), 1);
    step();
    chk("t1_mvalid_off", 32'(bus.m_tvalid), 0);
    wait_drain("t1_drain", 6);

    // Fairness: every source streams two 2-beat packets.
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < NSRC; s++)
        for (int b = 0; b < 2; b++) begin
          srcq[s].push_back(mk(8'(s*16 + p*2 + b), 2'(s), b == 1));
          expq.push_back(mk(8'(s*16 + p*2 + b), 2'(s), b == 1));
        end
    wait_grant(6);
    for (int k = 0; k < 8; k++) begin
      chk("rr_grant_a", 32'(grant), 32'(1 << (k % 4)));
      step();
      chk("rr_grant_b", 32'(grant), 32'(1 << (k % 4)));
      step();
      chk("rr_gap", 32'(grant), 0);
      step();
    end
    wait_drain("rr_drain", 6);

    // Rotation table: single-beat packets from varying request masks.
    do_reset();
    for (int k = 0; k < 11; k++) begin
      w = 0;
      for (int i = 0; i < NSRC; i++) if (vt[k].gnt[i]) w = i;
      for (int i = 0; i < NSRC; i++) begin
        srcq[i].delete();
        if (vt[k].req[i]) srcq[i].push_back(mk(8'(8'h40 + k*4 + i), 2'(i), 1'b1));
      end
      expq.push_back(mk(8'(8'h40 + k*4 + w), 2'(w), 1'b1));
      wait_grant(6);
      chk($sformatf("vec%0d_grant", k), 32'(grant), 32'(vt[k].gnt));
      for (int i = 0; i < NSRC; i++) if (i != w) srcq[i].delete();
      wait_drain($sformatf("vec%0d_drain", k), 8);
    end

    // Splice-rate backpressure with a long stall in the middle.
    do_reset();
    mr_mode = 1;
    for (int b = 0; b < 4; b++) begin
      srcq[2].push_back(mk(8'(8'hC0 + b), 2'd1, b == 3));
      expq.push_back(mk(8'(8'hC0 + b), 2'd1, b == 3));
    end
    wait_grant(6);
    for (int n = 0; n < 80 && expq.size() > 0; n++) begin
      step();
      if (grant[2] && bus.m_tvalid)
        chk("bp_tready", 32'(bus.s_tready[2]), 32'(bus.m_tready));
      if (expq.size() == 2 && mr_mode == 1 && n < 60) begin
        mr_mode = 2;
        repeat (24) begin
          step();
          chk("bp_no_abort", 32'(abort), 0);
          chk("bp_hold", 32'(grant), 32'b0100);
        end
        mr_mode = 3;
      end
      if (mr_mode == 3) mr_mode = 1;
    end
    chk("bp_drain", 32'(expq.size()), 0);
    chk("bp_acnt", 32'(acnt), 0);
    mr_mode = 0;

    // Watchdog: source 0 stalls mid-packet while source 3 waits.
    do_reset();
    srcq[0].push_back(mk(8'h55, 2'd0, 1'b0));
    srcq[3].push_back(mk(8'h77, 2'd3, 1'b1));
    expq.push_back(mk(8'h55, 2'd0, 1'b0));
    expq.push_back(mk(8'h77, 2'd3, 1'b1));
    wait_grant(6);
    chk("wd_grant0", 32'(grant), 32'b0001);
    for (int n = 0; n < 5 && !fire[0]; n++) step();
    t = cyc + 1;
    wait_abort(40);
    chk("wd_cycle", 32'(cyc - t), TIMEOUT);
    chk("wd_abort", 32'(abort), 1);
    chk("wd_grant_off", 32'(grant), 0);
    chk("wd_acnt", 32'(acnt), 1);
    step();
    chk("wd_pulse", 32'(abort), 0);
    wait_grant(6);
    chk("wd_next", 32'(grant), 32'b1000);
    wait_drain("wd_drain", 8);

    // Enable dropped mid-packet.
    do_reset();
    for (int b = 0; b < 3; b++) begin
      srcq[1].push_back(mk(8'(8'h91 + b), 2'd2, b == 2));
      expq.push_back(mk(8'(8'h91 + b), 2'd2, b == 2));
    end
    wait_grant(6);
    chk("en_grant1", 32'(grant), 32'b0010);
    en_n = 1'b0;
    srcq[2].push_back(mk(8'hB2, 2'd1, 1'b1));
    srcq[0].push_back(mk(8'hB0, 2'd3, 1'b1));
    expq.push_back(mk(8'hB2, 2'd1, 1'b1));
    for (int n = 0; n < 10 && grant != 0; n++) step();
    repeat (6) begin
      step();
      chk("en_hold", 32'(grant), 0);
    end
    chk("en_pkt_done", 32'(expq.size()), 1);
    expq.push_back(mk(8'hB0, 2'd3, 1'b1));
    en_n = 1'b1;
    wait_grant(6);
    chk("en_resume", 32'(grant), 32'b0100);
    wait_drain("en_drain", 12);

    // Abort counter saturation.
    do_reset();
    force dut.abort_count_q = 16'hFFFF;
    step();
    release dut.abort_count_q;
    step();
    chk("sat_pre", 32'(acnt), 32'hFFFF);
    srcq[0].push_back(mk(8'h66, 2'd0, 1'b0));
    expq.push_back(mk(8'h66, 2'd0, 1'b0));
    wait_grant(6);
    wait_abort(40);
    chk("sat_abort", 32'(abort), 1);
    chk("sat_acnt", 32'(acnt), 32'hFFFF);
    step();
    chk("sat_hold", 32'(acnt), 32'hFFFF);
    chk("sat_drain", 32'(expq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/turfio_mode1_arbiter.md
# turfio_mode1_arbiter

Round-robin packet arbiter that shares the single TURFIO-side mode1 stream feeding the command splice among NSRC local requesters (housekeeping, register readback, firmware-status sources). Each requester presents 8-bit mode1 data with a 2-bit mode1 type. Once a requester is granted, it holds the grant until its tlast beat transfers. A starvation watchdog releases a requester that stalls mid-packet. Output is one registered beat toward the splice, which accepts at most one beat per 8-cycle command frame.

## Interface
- NSRC, 4: number of requesters, 2..8.
- TIMEOUT, 1024: sysclk cycles with granted tvalid low mid-packet before abort; ≥2.
- sysclk_i  in  1  system clock.
- rstn_i  in  1  asynchronous, active-low reset.
- enable_i  in  1  arbitration enable; low blocks new grants only.
- s_tdata  in  8*NSRC  requester data, source i at [8i+7:8i].
- s_tuser  in  2*NSRC  requester mode1 type, source i at [2i+1:2i].
- s_tvalid  in  NSRC  requester valid.
- s_tlast  in  NSRC  requester last beat of packet.
- s_tready  out  NSRC  requester ready.
- m_tdata  out  8  mode1 data to splice.
- m_tuser  out  2  mode1 type to splice.
- m_tvalid  out  1  output beat valid.
- m_tready  in  1  splice accept.
- grant_o  out  NSRC  one-hot current grant; zero when idle.
- abort_o  out  1  one-cycle pulse on watchdog abort.
- abort_count_o  out  16  saturating abort count.

## Operation
- States: IDLE, PKT.
- IDLE: if enable_i and any s_tvalid, grant the first valid source strictly after last_grant, in ascending index with wrap. Latch grant and last_grant, then go to PKT. Otherwise stay in IDLE.
- last_grant resets to NSRC-1, so source 0 has first priority after reset.
- PKT: s_tready[g] = (!m_tvalid || m_tready), combinational. s_tready is 0 for all non-granted sources and in IDLE.
- Transfer when s_tvalid[g] && s_tready[g]: load m_tdata/m_tuser from source g and set m_tvalid.
- If m_tready && !transfer, clear m_tvalid.
- A transfer with s_tlast[g] high returns to IDLE and clears grant.
- Watchdog: a counter resets on entry to PKT and on every transfer. It increments in PKT while s_tvalid[g] is low. Output backpressure (s_tvalid high, s_tready low) does not count.
- When the counter reaches TIMEOUT-1:
  - return to IDLE and clear grant;
  - pulse abort_o;
  - increment abort_count_o, saturating at 0xFFFF;
  - keep last_grant, so the aborted source goes to the back of the rotation.
- No beat is injected on abort.
- An output beat already in m_tdata stays valid until accepted.
- enable_i falling in PKT has no effect until the packet ends.
- tuser is passed per beat without checking. The splice uses it as the mode1 type.

## Timing
- Reset (rstn_i low, asynchronous):
  - state IDLE, grant_o 0, last_grant NSRC-1;
  - m_tvalid 0, m_tdata 0, m_tuser 0;
  - s_tready 0, abort_o 0, abort_count_o 0, watchdog 0.
- Reset asserted mid-packet drops the packet silently; abort_count is not incremented.
- Grant latency: s_tvalid rises at cycle n in IDLE → grant_o valid and state PKT at n+1 → s_tready[g] high at n+1 → m_tvalid high at n+2.
- Throughput: one beat per cycle when m_tready is held high. One dead cycle (IDLE) between packets.
- tlast transfer at cycle k → grant_o 0 at k+1 → next grant at k+2.
- Simultaneous transfer and m_tready in the same cycle: m_tvalid stays 1 with new data; no bubble.
- Watchdog: with no transfer after cycle t, abort_o pulses at cycle t+TIMEOUT and grant_o is 0 at t+TIMEOUT. abort_o and grant release are in the same cycle.
- Single-beat packet (tlast on first beat) is legal.
- Requests arriving in the abort cycle are considered on the following IDLE cycle.

## Test plan
- Reset and single source:
  - Stimulus: hold rstn_i low, then release; source 1 sends 3 beats 0xA1, 0xA2, 0xA3 (tuser 2'b10, tlast on 0xA3) with m_tready tied 1.
  - Required: all outputs 0 during reset; grant_o = 4'b0010; m_tdata sequence A1, A2, A3 with m_tuser 2'b10; grant_o 0 the cycle after A3 transfers.
- Round-robin fairness:
  - Stimulus: all 4 sources continuously request 2-beat packets.
  - Required: grant order 0, 1, 2, 3, 0, 1…; each packet contiguous on m_tdata; exactly one idle cycle between packets.
- Splice-rate backpressure:
  - Stimulus: m_tready pulses one cycle in every 8; source 2 sends 4 beats.
  - Required: no beat lost or duplicated; s_tready[2] follows m_tready once the output register fills; watchdog never fires.
- Watchdog abort:
  - Stimulus: TIMEOUT=16; source 0 sends 1 beat without tlast, then drops tvalid; source 3 is requesting.
  - Required: abort_o pulses exactly 16 cycles after the last transfer; abort_count_o = 1; next grant is source 3.
- Enable gating:
  - Stimulus: drop enable_i mid-packet on source 1.
  - Required: packet completes through tlast; no new grant while enable_i is low; grant resumes with source 2 when enable_i returns high.
- Abort-count saturation:
  - Stimulus: force 0xFFFF then one more abort.
  - Required: abort_count_o holds 0xFFFF; abort_o still pulses.
